// File: rtl/tipi_pkg.sv
// Shared constants and helpers for the TIPI Pi mailbox: synchronizer depth,
// even parity, and channel-range decoding.
package tipi_pkg;

    localparam int SYNC_STAGES = 2;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

    function automatic logic is_out_ch(input int unsigned ch, input int unsigned n_out);
        return ch < n_out;
    endfunction

    function automatic logic is_in_ch(input int unsigned ch, input int unsigned n_out,
                                      input int unsigned n_in);
        return (ch >= n_out) && (ch < n_out + n_in);
    endfunction

endpackage

// File: rtl/tipi_sync_edge.sv
// Two-flop synchronizer for an asynchronous Pi strobe, followed by a
// rising-edge detector that yields a one-cycle pulse in the clk domain.
module tipi_sync_edge
    import tipi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/tipi_pi_mailbox.sv
// TI <-> Raspberry Pi mailbox with one system-clocked serial shift engine.
// Define TIPI_PI_PARITY_EN to append/check an even-parity bit on every frame.
module tipi_pi_mailbox
    import tipi_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int OUT_CH = 2,
    parameter int IN_CH  = 2,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r_clk,
    input  logic              r_le,
    input  logic [SEL_W-1:0]  r_sel,
    input  logic              r_dout,
    output logic              r_din,
    input  logic              ti_wr_en,
    input  logic [SEL_W-1:0]  ti_wr_ch,
    input  logic [WIDTH-1:0]  ti_wr_data,
    input  logic [SEL_W-1:0]  ti_rd_ch,
    output logic [WIDTH-1:0]  ti_rd_data,
    output logic [IN_CH-1:0]  in_strobe,
    output logic [OUT_CH-1:0] out_taken,
    output logic              frame_err,
    output logic              parity_err,
    input  logic              err_clr
);

`ifdef TIPI_PI_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int              CW      = $clog2(FL + 2);
    localparam logic [CW-1:0]   FL_CNT  = CW'(FL);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FL + 1);

    logic clk_rise;
    logic le_rise;

    tipi_sync_edge u_clk_edge (.clk(clk), .reset(reset), .d(r_clk), .rise(clk_rise));
    tipi_sync_edge u_le_edge  (.clk(clk), .reset(reset), .d(r_le),  .rise(le_rise));

    // r_sel and r_dout only need to be stable, so a plain synchronizer is enough.
    logic [SYNC_STAGES-1:0][SEL_W:0] bus_sync_reg;
    logic [SEL_W-1:0]                sel_s;
    logic                            dout_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_sync_reg <= '0;
        end else begin
            bus_sync_reg[0] <= {r_sel, r_dout};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bus_sync_reg[i] <= bus_sync_reg[i-1];
            end
        end
    end

    assign sel_s  = bus_sync_reg[SYNC_STAGES-1][SEL_W:1];
    assign dout_s = bus_sync_reg[SYNC_STAGES-1][0];

    logic sel_out;
    logic sel_in;
    assign sel_out = is_out_ch(32'(sel_s), OUT_CH);
    assign sel_in  = is_in_ch(32'(sel_s), OUT_CH, IN_CH);

    logic [FL-1:0]             sr_reg;
    logic [CW-1:0]             cnt_reg;
    logic                      frame_err_reg;
    logic [OUT_CH-1:0][WIDTH-1:0] out_bus;
    logic [IN_CH-1:0][WIDTH-1:0]  in_bus;

    logic le_out, le_in, le_bad, full, commit, set_frame;
    assign le_out    = le_rise & sel_out;
    assign le_in     = le_rise & sel_in;
    assign le_bad    = le_rise & ~sel_in & ~sel_out;
    assign full      = (cnt_reg == FL_CNT);
    assign set_frame = (le_in & ~full) | le_bad;

    // A TI write landing on the load cycle of the same channel is forwarded.
    logic [WIDTH-1:0] load_data;
    always_comb begin
        load_data = '0;
        for (int i = 0; i < OUT_CH; i++) begin
            if (sel_s == SEL_W'(i)) load_data = out_bus[i];
        end
        if (ti_wr_en && ti_wr_ch == sel_s) load_data = ti_wr_data;
    end

    logic [WIDTH-1:0] frame_data;
    logic [FL-1:0]    load_frame;
    logic             par_ok;
`ifdef TIPI_PI_PARITY_EN
    logic set_par;
    logic parity_err_reg;
    assign frame_data = sr_reg[FL-1 -: WIDTH];
    assign par_ok     = (even_parity(64'(frame_data)) == sr_reg[0]);
    assign load_frame = {load_data, even_parity(64'(load_data))};
    assign set_par    = le_in & full & ~par_ok;
    assign parity_err = parity_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        parity_err_reg <= 1'b0;
        else if (err_clr) parity_err_reg <= 1'b0;
        else if (set_par) parity_err_reg <= 1'b1;
    end
`else
    assign frame_data = sr_reg;
    assign par_ok     = 1'b1;
    assign load_frame = load_data;
    assign parity_err = 1'b0;
`endif

    assign commit = le_in & full & par_ok;

    // r_le outranks a same-cycle r_clk; an invalid select leaves sr and cnt alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg        <= '0;
            cnt_reg       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            if (le_out) begin
                sr_reg  <= load_frame;
                cnt_reg <= '0;
            end else if (le_in) begin
                cnt_reg <= '0;
            end else if (clk_rise && !le_rise) begin
                sr_reg <= {sr_reg[FL-2:0], dout_s};
                if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
            end

            if (err_clr)        frame_err_reg <= 1'b0;
            else if (set_frame) frame_err_reg <= 1'b1;
        end
    end

    assign r_din     = sr_reg[FL-1];
    assign frame_err = frame_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_CH; gi++) begin : g_out
            logic [WIDTH-1:0] data_reg;
            logic             taken_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg  <= '0;
                    taken_reg <= 1'b0;
                end else begin
                    if (ti_wr_en && ti_wr_ch == SEL_W'(gi)) data_reg <= ti_wr_data;
                    taken_reg <= le_out && (sel_s == SEL_W'(gi));
                end
            end
            assign out_bus[gi]   = data_reg;
            assign out_taken[gi] = taken_reg;
        end

        for (gi = 0; gi < IN_CH; gi++) begin : g_in
            logic [WIDTH-1:0] data_reg;
            logic             strobe_reg;
            logic             hit;
            assign hit = commit && (sel_s == SEL_W'(OUT_CH + gi));
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg   <= '0;
                    strobe_reg <= 1'b0;
                end else begin
                    if (hit) data_reg <= frame_data;
                    strobe_reg <= hit;
                end
            end
            assign in_bus[gi]    = data_reg;
            assign in_strobe[gi] = strobe_reg;
        end
    endgenerate

    always_comb begin
        ti_rd_data = '0;
        for (int i = 0; i < IN_CH; i++) begin
            if (ti_rd_ch == SEL_W'(OUT_CH + i)) ti_rd_data = in_bus[i];
        end
    end

endmodule

// File: tb/tb_tipi_pi_mailbox.sv
// Directed bench for tipi_pi_mailbox: scoreboard queues for commits, loads
// and shifted-out bits, checked with immediate assertions.
module tb_tipi_pi_mailbox;

    localparam int WIDTH  = 8;
    localparam int OUT_CH = 2;
    localparam int IN_CH  = 2;
    localparam int SEL_W  = 2;
`ifdef TIPI_PI_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              r_clk, r_le, r_dout, r_din;
    logic [SEL_W-1:0]  r_sel;
    logic              ti_wr_en;
    logic [SEL_W-1:0]  ti_wr_ch, ti_rd_ch;
    logic [WIDTH-1:0]  ti_wr_data, ti_rd_data;
    logic [IN_CH-1:0]  in_strobe;
    logic [OUT_CH-1:0] out_taken;
    logic              frame_err, parity_err, err_clr;

    tipi_pi_mailbox #(.WIDTH(WIDTH), .OUT_CH(OUT_CH), .IN_CH(IN_CH), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .r_clk(r_clk), .r_le(r_le), .r_sel(r_sel),
        .r_dout(r_dout), .r_din(r_din), .ti_wr_en(ti_wr_en), .ti_wr_ch(ti_wr_ch),
        .ti_wr_data(ti_wr_data), .ti_rd_ch(ti_rd_ch), .ti_rd_data(ti_rd_data),
        .in_strobe(in_strobe), .out_taken(out_taken), .frame_err(frame_err),
        .parity_err(parity_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [IN_CH-1:0] strobe;
        logic [WIDTH-1:0] data;
    } commit_t;

    commit_t           commit_q[$];
    logic [OUT_CH-1:0] taken_q[$];
    logic              din_q[$];
    commit_t           mon_c;
    logic [OUT_CH-1:0] mon_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [7:0] d);
`ifdef TIPI_PI_PARITY_EN
        return {23'b0, d, ^d};
`else
        return {24'b0, d};
`endif
    endfunction

    // side: 0 none, 1 TI write to the same channel on the action cycle, 2 err_clr on it
    task automatic pi_le(input int sel, input int side, input logic [7:0] wdata);
        r_sel = 2'(sel);
        step(4);
        r_le = 1'b1;
        step(2);
        if (side == 1) begin
            ti_wr_en   = 1'b1;
            ti_wr_ch   = 2'(sel);
            ti_wr_data = wdata;
        end
        if (side == 2) err_clr = 1'b1;
        step(1);
        ti_wr_en = 1'b0;
        err_clr  = 1'b0;
        step(1);
        r_le = 1'b0;
        step(4);
    endtask

    task automatic xfer(input logic [31:0] in_frame, input int n, input logic chk,
                        input logic [31:0] out_frame);
        if (chk) for (int i = FL - 1; i >= 0; i--) din_q.push_back(out_frame[i]);
        for (int i = n - 1; i >= 0; i--) begin
            if (chk && din_q.size() > 0) check("r_din", 32'(r_din), 32'(din_q.pop_front()));
            r_dout = in_frame[i];
            step(4);
            r_clk = 1'b1;
            step(4);
            r_clk = 1'b0;
        end
        step(4);
    endtask

    task automatic ti_write(input int ch, input logic [7:0] d);
        ti_wr_en   = 1'b1;
        ti_wr_ch   = 2'(ch);
        ti_wr_data = d;
        step(1);
        ti_wr_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (in_strobe !== '0) begin
                if (commit_q.size() == 0) begin
                    check("unexpected_in_strobe", 32'(in_strobe), 32'h0);
                end else begin
                    mon_c = commit_q.pop_front();
                    check("in_strobe", 32'(in_strobe), 32'(mon_c.strobe));
                    check("ti_rd_data_at_commit", 32'(ti_rd_data), 32'(mon_c.data));
                end
            end
            if (out_taken !== '0) begin
                if (taken_q.size() == 0) begin
                    check("unexpected_out_taken", 32'(out_taken), 32'h0);
                end else begin
                    mon_t = taken_q.pop_front();
                    check("out_taken", 32'(out_taken), 32'(mon_t));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; r_clk = 1'b0; r_le = 1'b0; r_sel = '0; r_dout = 1'b0;
        ti_wr_en = 1'b0; ti_wr_ch = '0; ti_wr_data = '0; ti_rd_ch = 2'd2; err_clr = 1'b0;
        step(2);
        check("reset_r_din", 32'(r_din), 32'h0);
        check("reset_in_strobe", 32'(in_strobe), 32'h0);
        check("reset_out_taken", 32'(out_taken), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_rd_ch2", 32'(ti_rd_data), 32'h0);
        reset = 1'b0;
        step(2);

        // Outbound 0xA5 on ch0 while 0x3C shifts in, then commit to ch2
        ti_write(0, 8'hA5);
        taken_q.push_back(2'b01);
        pi_le(0, 0, 8'h00);
        xfer(mk(8'h3C), FL, 1'b1, mk(8'hA5));
        ti_rd_ch = 2'd2;
        commit_q.push_back('{2'b01, 8'h3C});
        pi_le(2, 0, 8'h00);
        check("frame_err_after_good", 32'(frame_err), 32'h0);

        // Good frame to ch3, then a short frame
        ti_rd_ch = 2'd3;
        xfer(mk(8'hC3), FL, 1'b0, 32'h0);
        commit_q.push_back('{2'b10, 8'hC3});
        pi_le(3, 0, 8'h00);
        xfer(mk(8'h0F), FL - 1, 1'b0, 32'h0);
        pi_le(3, 0, 8'h00);
        check("short_frame_err", 32'(frame_err), 32'h1);
        check("short_no_commit", 32'(ti_rd_data), 32'hC3);
        err_clr = 1'b1; step(1); err_clr = 1'b0; step(1);
        check("err_clr", 32'(frame_err), 32'h0);

        // Outbound channel indices read as zero; TI writes to inbound indices ignored
        ti_rd_ch = 2'd0; step(1);
        check("rd_outbound_ch0", 32'(ti_rd_data), 32'h0);
        ti_rd_ch = 2'd1; step(1);
        check("rd_outbound_ch1", 32'(ti_rd_data), 32'h0);
        ti_write(2, 8'hFF);
        ti_rd_ch = 2'd2; step(1);
        check("wr_inbound_ignored", 32'(ti_rd_data), 32'h3C);

        // Same-cycle TI write and Pi load of ch1: bypass
        ti_write(1, 8'h77);
        taken_q.push_back(2'b10);
        pi_le(1, 1, 8'h5A);
        xfer(mk(8'h96), FL, 1'b1, mk(8'h5A));
        commit_q.push_back('{2'b01, 8'h96});
        pi_le(2, 0, 8'h00);
        taken_q.push_back(2'b10);
        pi_le(1, 0, 8'h00);
        xfer(mk(8'h00), FL, 1'b1, mk(8'h5A));

        // Reset in the middle of an inbound frame
        xfer(mk(8'hFF), 4, 1'b0, 32'h0);
        reset = 1'b1; step(2); reset = 1'b0; step(2);
        check("reset_clears_ch2", 32'(ti_rd_data), 32'h0);
        ti_rd_ch = 2'd3; step(1);
        check("reset_clears_ch3", 32'(ti_rd_data), 32'h0);
        ti_rd_ch = 2'd2;
        xfer(mk(8'h69), FL, 1'b0, 32'h0);
        commit_q.push_back('{2'b01, 8'h69});
        pi_le(2, 0, 8'h00);
        check("fresh_frame_err", 32'(frame_err), 32'h0);
        check("fresh_parity_err", 32'(parity_err), 32'h0);

        // Overlong frames: err_clr wins on the same cycle; counter must saturate
        ti_rd_ch = 2'd3;
        xfer(32'h5A5A_5A5A, FL + 3, 1'b0, 32'h0);
        pi_le(3, 2, 8'h00);
        check("err_clr_priority", 32'(frame_err), 32'h0);
        xfer(32'h0000_A5A5, FL + 16, 1'b0, 32'h0);
        pi_le(3, 0, 8'h00);
        check("overrun_frame_err", 32'(frame_err), 32'h1);
        check("overrun_no_commit", 32'(ti_rd_data), 32'h0);
        err_clr = 1'b1; step(1); err_clr = 1'b0; step(1);
        check("err_clr_again", 32'(frame_err), 32'h0);

`ifdef TIPI_PI_PARITY_EN
        ti_rd_ch = 2'd2;
        xfer({23'b0, 8'h01, 1'b0}, FL, 1'b0, 32'h0);
        pi_le(2, 0, 8'h00);
        check("bad_parity_err", 32'(parity_err), 32'h1);
        check("bad_parity_no_commit", 32'(ti_rd_data), 32'h69);
        check("bad_parity_frame_ok", 32'(frame_err), 32'h0);
        err_clr = 1'b1; step(1); err_clr = 1'b0; step(1);
        xfer({23'b0, 8'h01, 1'b1}, FL, 1'b0, 32'h0);
        commit_q.push_back('{2'b01, 8'h01});
        pi_le(2, 0, 8'h00);
        check("good_parity_err", 32'(parity_err), 32'h0);
`endif

        step(6);
        check("commit_q_drained", 32'(commit_q.size()), 32'h0);
        check("taken_q_drained", 32'(taken_q.size()), 32'h0);
        check("din_q_drained", 32'(din_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
